// File: rtl/clk_div_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank_pkg
// Description : Shared constants, channel state record and width helper for
//               the clk_div_bank programmable divider bank.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_bank_pkg;

  localparam int MIN_DIV   = 2;
  // Internal counter width; channel divisors up to this many bits are carried
  // zero-extended so one state record serves every DIV_W configuration.
  localparam int DIV_MAX_W = 16;

  typedef struct packed {
    logic [DIV_MAX_W-1:0] cnt;
    logic [DIV_MAX_W-1:0] div;
    logic [DIV_MAX_W-1:0] shadow;
    logic                 pending;
  } chan_state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel: period counter, shadow/pending divisor
//               and registered clk_out/tick generation.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_div,
  output logic             o_pending,
  output logic             o_clk_out,
  output logic             o_tick
);

  localparam logic [DIV_MAX_W-1:0] c_div_rst = DIV_MAX_W'(DEFAULT_DIV);
  localparam logic [DIV_MAX_W-1:0] c_one     = DIV_MAX_W'(1);

  chan_state_t r_st;
  chan_state_t w_st_nxt;
  logic        w_wrap;
  logic        w_boundary;
  logic        r_clk_out;
  logic        r_tick;

  always_comb begin
    w_st_nxt   = r_st;
    w_wrap     = (r_st.cnt == (r_st.div - c_one));
    w_boundary = !i_en || i_sync || w_wrap;

    w_st_nxt.cnt = w_boundary ? '0 : (r_st.cnt + c_one);

    if (w_boundary && r_st.pending) begin
      w_st_nxt.div     = r_st.shadow;
      w_st_nxt.pending = 1'b0;
    end

    // A write is only ever granted while pending is clear, so a write that
    // lands on a boundary always waits for the following one.
    if (i_wr) begin
      w_st_nxt.shadow  = DIV_MAX_W'(i_wr_div);
      w_st_nxt.pending = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_st      <= '{cnt: '0, div: c_div_rst, shadow: c_div_rst, pending: 1'b0};
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_clk_out <= i_en && (w_st_nxt.cnt >= (w_st_nxt.div >> 1));
      r_tick    <= i_en && (w_st_nxt.cnt == (w_st_nxt.div - c_one));
    end
  end

  assign o_pending = r_st.pending;
  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank
// Description : NUM_CH programmable clock dividers with a valid/ready config
//               port; optional CLKDIV_SYNC_EN adds a sync_req restart input.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_W       = 8,
  parameter  int DEFAULT_DIV = 4,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              reset_n,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_req,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;
  logic              w_accept;
  logic              w_div_ok;
  logic              w_sync;
  logic              r_cfg_err;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync_req;
`else
  assign w_sync = 1'b0;
`endif

  // An out-of-range channel selects nothing, so it always reads as ready.
  assign cfg_ready = ~|(w_sel & w_pending);
  assign w_accept  = cfg_valid & cfg_ready;
  assign w_div_ok  = (cfg_div >= DIV_W'(MIN_DIV));

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      assign w_sel[i] = (cfg_ch == CH_W'(i));
      assign w_wr[i]  = w_accept & w_sel[i] & w_div_ok;

      clk_div_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .i_en      (ch_en[i]),
        .i_sync    (w_sync),
        .i_wr      (w_wr[i]),
        .i_wr_div  (cfg_div),
        .o_pending (w_pending[i]),
        .o_clk_out (clk_out[i]),
        .o_tick    (tick[i])
      );
    end
  endgenerate

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_accept & (~|w_sel | ~w_div_ok);
    end
  end

  assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_bank
// Description : Self-checking bench for clk_div_bank (scoreboard of expected
//               per-cycle clk_out/tick values plus inline handshake checks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] ch_en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_err;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic       sync_req;

  logic [2:0] ch_en3;
  logic       cfg_valid3;
  logic       cfg_ready3;
  logic [1:0] cfg_ch3;
  logic [7:0] cfg_div3;
  logic       cfg_err3;
  logic [2:0] clk_out3;
  logic [2:0] tick3;

  clk_div_bank #(.NUM_CH(4), .DIV_W(8), .DEFAULT_DIV(4)) u_dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
`ifdef CLKDIV_SYNC_EN
    .sync_req  (sync_req),
`endif
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // Three channels leave channel index 3 unpopulated for out-of-range writes.
  clk_div_bank #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(4)) u_dut3 (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
`ifdef CLKDIV_SYNC_EN
    .sync_req  (sync_req),
`endif
    .ch_en     (ch_en3),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch3),
    .cfg_div   (cfg_div3),
    .cfg_err   (cfg_err3),
    .clk_out   (clk_out3),
    .tick      (tick3)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int   cyc;
    int   ch;
    logic clk;
    logic tck;
  } exp_t;
  exp_t sb[$];

  function automatic void push_one(int c, int ch, logic clk, logic tck);
    exp_t e;
    e.cyc = c; e.ch = ch; e.clk = clk; e.tck = tck;
    sb.push_back(e);
  endfunction

  // Expected waveform for divisor n whose cnt=0 cycle is at 'origin'.
  function automatic void push_pat(int ch, int from, int to, int n, int origin);
    for (int c = from; c <= to; c++) begin
      int p;
      p = (c - origin) % n;
      push_one(c, ch, (p >= n / 2), (p == n - 1));
    end
  endfunction

  task automatic do_reset(output int base);
    @(negedge clk_in);
    reset_n = 1'b0; ch_en = '1; ch_en3 = '1; sync_req = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_div3 = '0;
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    base = cyc;
  endtask

  task automatic test_reset();
    int base;
    @(negedge clk_in);
    reset_n = 1'b0; ch_en = '1; ch_en3 = '1; sync_req = 1'b0;
    cfg_valid = 1'b0; cfg_ch = 2'd1; cfg_div = '0;
    cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_div3 = '0;
    @(negedge clk_in);
    n_checks++;
    if (clk_out !== 4'b0 || tick !== 4'b0 || cfg_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: clk_out=%b tick=%b cfg_err=%b, expected 0000 0000 0", clk_out, tick, cfg_err);
    end
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: cfg_ready=%b, expected 1", cfg_ready);
    end
    reset_n = 1'b1;
    base = cyc;
    for (int ch = 0; ch < 4; ch++) push_pat(ch, base, base + 11, 4, base);
    for (int k = 0; k <= 11; k++) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_checks++;
          if (clk_out[sb[i].ch] !== sb[i].clk || tick[sb[i].ch] !== sb[i].tck) begin
            n_err++;
            $display("FAIL reset_pattern k=%0d ch%0d: clk_out=%b tick=%b, expected %b %b",
                     k, sb[i].ch, clk_out[sb[i].ch], tick[sb[i].ch], sb[i].clk, sb[i].tck);
          end
          sb.delete(i);
        end
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_cfg_write();
    int base;
    do_reset(base);
    push_pat(0, base, base + 20, 4, base);
    push_pat(1, base, base + 7, 4, base);
    push_pat(1, base + 8, base + 20, 5, base + 8);
    for (int k = 0; k <= 20; k++) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_checks++;
          if (clk_out[sb[i].ch] !== sb[i].clk || tick[sb[i].ch] !== sb[i].tck) begin
            n_err++;
            $display("FAIL cfg_write k=%0d ch%0d: clk_out=%b tick=%b, expected %b %b",
                     k, sb[i].ch, clk_out[sb[i].ch], tick[sb[i].ch], sb[i].clk, sb[i].tck);
          end
          sb.delete(i);
        end
      end
      if (k == 5) begin
        cfg_ch = 2'd1; cfg_div = 8'd5; cfg_valid = 1'b1;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
          n_err++; $display("FAIL cfg_write_ready_idle: cfg_ready=%b, expected 1", cfg_ready);
        end
      end else if (k == 6 || k == 7) begin
        cfg_valid = 1'b0;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
          n_err++;
          $display("FAIL cfg_write_pending k=%0d: cfg_ready=%b cfg_err=%b, expected 0 0", k, cfg_ready, cfg_err);
        end
      end else if (k == 8) begin
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
          n_err++; $display("FAIL cfg_write_applied: cfg_ready=%b, expected 1", cfg_ready);
        end
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_cfg_err();
    int base;
    do_reset(base);
    push_pat(0, base, base + 12, 4, base);
    push_pat(2, base, base + 12, 4, base);
    for (int k = 0; k <= 12; k++) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_checks++;
          if (clk_out[sb[i].ch] !== sb[i].clk || tick[sb[i].ch] !== sb[i].tck) begin
            n_err++;
            $display("FAIL cfg_err k=%0d ch%0d: clk_out=%b tick=%b, expected %b %b",
                     k, sb[i].ch, clk_out[sb[i].ch], tick[sb[i].ch], sb[i].clk, sb[i].tck);
          end
          sb.delete(i);
        end
      end
      case (k)
        1: begin
          cfg_ch = 2'd2; cfg_div = 8'd1; cfg_valid = 1'b1;
          #1;
          n_checks++;
          if (cfg_ready !== 1'b1) begin
            n_err++; $display("FAIL err_div1_ready: cfg_ready=%b, expected 1", cfg_ready);
          end
        end
        2: begin
          cfg_valid = 1'b0;
          #1;
          n_checks++;
          if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL err_div1_pulse: cfg_err=%b cfg_ready=%b, expected 1 1", cfg_err, cfg_ready);
          end
        end
        4: begin
          cfg_div = 8'd0; cfg_valid = 1'b1;
          cfg_ch3 = 2'd3; cfg_div3 = 8'd5; cfg_valid3 = 1'b1;
          #1;
          n_checks++;
          if (cfg_ready3 !== 1'b1) begin
            n_err++; $display("FAIL err_badch_ready: cfg_ready=%b, expected 1", cfg_ready3);
          end
        end
        5: begin
          cfg_valid = 1'b0; cfg_valid3 = 1'b0;
          #1;
          n_checks++;
          if (cfg_err !== 1'b1 || cfg_err3 !== 1'b1) begin
            n_err++;
            $display("FAIL err_pulse_b: cfg_err=%b cfg_err3=%b, expected 1 1", cfg_err, cfg_err3);
          end
        end
        3, 6: begin
          #1;
          n_checks++;
          if (cfg_err !== 1'b0 || cfg_err3 !== 1'b0) begin
            n_err++;
            $display("FAIL err_one_cycle k=%0d: cfg_err=%b cfg_err3=%b, expected 0 0", k, cfg_err, cfg_err3);
          end
          if (k == 6) begin
            n_checks++;
            if (clk_out3 !== 3'b111) begin
              n_err++; $display("FAIL err_badch_phase: clk_out=%b, expected 111", clk_out3);
            end
          end
        end
        7: begin
          cfg_div = 8'd1; cfg_valid = 1'b1;
          #1;
          n_checks++;
          if (tick3 !== 3'b111) begin
            n_err++; $display("FAIL err_badch_tick: tick=%b, expected 111", tick3);
          end
        end
        8, 9: begin
          cfg_valid = (k == 8);
          #1;
          n_checks++;
          if (cfg_err !== 1'b1) begin
            n_err++; $display("FAIL err_back_to_back k=%0d: cfg_err=%b, expected 1", k, cfg_err);
          end
        end
        10: begin
          #1;
          n_checks++;
          if (cfg_err !== 1'b0) begin
            n_err++; $display("FAIL err_b2b_end: cfg_err=%b, expected 0", cfg_err);
          end
        end
        default: ;
      endcase
      @(negedge clk_in);
    end
  endtask

  task automatic test_write_on_tick();
    int base;
    do_reset(base);
    push_pat(0, base, base + 7, 4, base);
    push_pat(0, base + 8, base + 20, 6, base + 8);
    push_pat(1, base, base + 20, 4, base);
    for (int k = 0; k <= 20; k++) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_checks++;
          if (clk_out[sb[i].ch] !== sb[i].clk || tick[sb[i].ch] !== sb[i].tck) begin
            n_err++;
            $display("FAIL write_on_tick k=%0d ch%0d: clk_out=%b tick=%b, expected %b %b",
                     k, sb[i].ch, clk_out[sb[i].ch], tick[sb[i].ch], sb[i].clk, sb[i].tck);
          end
          sb.delete(i);
        end
      end
      if (k == 3) begin
        cfg_ch = 2'd0; cfg_div = 8'd6; cfg_valid = 1'b1;
      end else if (k == 4 || k == 8) begin
        cfg_valid = 1'b0;
        #1;
        n_checks++;
        if (cfg_ready !== (k == 8)) begin
          n_err++;
          $display("FAIL write_on_tick_ready k=%0d: cfg_ready=%b, expected %b", k, cfg_ready, (k == 8));
        end
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_disable();
    int base;
    do_reset(base);
    push_pat(0, base, base + 14, 4, base);
    push_pat(3, base, base + 2, 4, base);
    push_one(base + 3, 3, 1'b0, 1'b0);
    push_one(base + 4, 3, 1'b0, 1'b0);
    push_pat(3, base + 5, base + 14, 4, base + 5);
    for (int k = 0; k <= 14; k++) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_checks++;
          if (clk_out[sb[i].ch] !== sb[i].clk || tick[sb[i].ch] !== sb[i].tck) begin
            n_err++;
            $display("FAIL disable k=%0d ch%0d: clk_out=%b tick=%b, expected %b %b",
                     k, sb[i].ch, clk_out[sb[i].ch], tick[sb[i].ch], sb[i].clk, sb[i].tck);
          end
          sb.delete(i);
        end
      end
      if (k == 2) ch_en[3] = 1'b0;
      if (k == 5) ch_en[3] = 1'b1;
      @(negedge clk_in);
    end
  endtask

  task automatic test_reset_pending();
    int base;
    do_reset(base);
    @(negedge clk_in);
    cfg_ch = 2'd1; cfg_div = 8'd5; cfg_valid = 1'b1;
    @(negedge clk_in);
    cfg_valid = 1'b0;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_pending_set: cfg_ready=%b, expected 0", cfg_ready);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || clk_out !== 4'b0) begin
      n_err++;
      $display("FAIL rst_pending_clear: cfg_ready=%b clk_out=%b, expected 1 0000", cfg_ready, clk_out);
    end
    @(negedge clk_in);
    reset_n = 1'b1;
    base = cyc;
    push_pat(1, base, base + 11, 4, base);
    for (int k = 0; k <= 11; k++) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_checks++;
          if (clk_out[sb[i].ch] !== sb[i].clk || tick[sb[i].ch] !== sb[i].tck) begin
            n_err++;
            $display("FAIL rst_pending k=%0d ch%0d: clk_out=%b tick=%b, expected %b %b",
                     k, sb[i].ch, clk_out[sb[i].ch], tick[sb[i].ch], sb[i].clk, sb[i].tck);
          end
          sb.delete(i);
        end
      end
      @(negedge clk_in);
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    int base;
    do_reset(base);
    push_pat(0, base, base + 13, 4, base);
    push_pat(0, base + 14, base + 17, 4, base + 14);
    push_pat(0, base + 18, base + 26, 3, base + 18);
    push_pat(1, base, base + 3, 4, base);
    push_pat(1, base + 4, base + 13, 6, base + 4);
    push_pat(1, base + 14, base + 26, 6, base + 14);
    push_pat(2, base, base + 13, 4, base);
    push_pat(2, base + 14, base + 26, 4, base + 14);
    for (int k = 0; k <= 26; k++) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_checks++;
          if (clk_out[sb[i].ch] !== sb[i].clk || tick[sb[i].ch] !== sb[i].tck) begin
            n_err++;
            $display("FAIL sync k=%0d ch%0d: clk_out=%b tick=%b, expected %b %b",
                     k, sb[i].ch, clk_out[sb[i].ch], tick[sb[i].ch], sb[i].clk, sb[i].tck);
          end
          sb.delete(i);
        end
      end
      if (k == 0) begin
        cfg_ch = 2'd1; cfg_div = 8'd6; cfg_valid = 1'b1;
      end else if (k == 1) begin
        cfg_valid = 1'b0;
      end else if (k == 13) begin
        sync_req = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3; cfg_valid = 1'b1;
      end else if (k == 14) begin
        sync_req = 1'b0; cfg_valid = 1'b0;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
          n_err++; $display("FAIL sync_write_pending: cfg_ready=%b, expected 0", cfg_ready);
        end
      end
      @(negedge clk_in);
    end
  endtask
`endif

  initial begin
    ch_en = '1; ch_en3 = '1; sync_req = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_div3 = '0;
    test_reset();
    test_cfg_write();
    test_cfg_err();
    test_write_on_tick();
    test_disable();
    test_reset_pending();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
